// File: rtl/tick_timer_ctrl_if.sv
// Command/status bundle between a controller and the tick_timer_ctrl block.
interface tick_timer_ctrl_if #(
  parameter int unsigned SEC_W = 8
);
  logic             start;
  logic             pause;
  logic             clear;
  logic [SEC_W-1:0] load_val;
  logic [SEC_W-1:0] remaining;
  logic             tick_out;
  logic             done;
  logic             expired;
  logic             busy;
  logic [1:0]       state;

  modport master (
    output start, pause, clear, load_val,
    input  remaining, tick_out, done, expired, busy, state
  );

  modport slave (
    input  start, pause, clear, load_val,
    output remaining, tick_out, done, expired, busy, state
  );
endinterface

// File: rtl/tick_timer_ctrl.sv
// Countdown timer controller: a gated prescaler produces one enable tick per
// DIV system clocks while running, and the loaded seconds value counts down.
// Optional feature: define TICK_TIMER_AUTO_RELOAD_EN to re-arm from the reload
// latch on expiry instead of entering DONE.
module tick_timer_ctrl #(
  parameter int unsigned DIV   = 10000000,
  parameter int unsigned PRE_W = 24,
  parameter int unsigned SEC_W = 8
) (
  input logic              clk,
  input logic              reset,
  tick_timer_ctrl_if.slave bus
);

  localparam logic [PRE_W-1:0] P_LAST  = PRE_W'(DIV - 1);
  localparam logic [SEC_W-1:0] SEC_ONE = SEC_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [PRE_W-1:0] p_q, p_d;
  logic [SEC_W-1:0] rem_q, rem_d;
  logic [SEC_W-1:0] reload_q, reload_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;
  logic             expired_q, expired_d;
  logic             busy_q, busy_d;

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      p_q       <= '0;
      rem_q     <= '0;
      reload_q  <= '0;
      tick_q    <= 1'b0;
      done_q    <= 1'b0;
      expired_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      p_q       <= p_d;
      rem_q     <= rem_d;
      reload_q  <= reload_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
      expired_q <= expired_d;
      busy_q    <= busy_d;
    end
  end

  // Next state: clear beats start beats pause; a PAUSE edge releasing pause
  // counts like a RUN edge so no prescaler cycle is lost on resume.
  always_comb begin
    state_d  = state_q;
    p_d      = p_q;
    rem_d    = rem_q;
    reload_d = reload_q;
    tick_d   = 1'b0;
    done_d   = 1'b0;

    if (bus.clear) begin
      state_d = IDLE;
      p_d     = '0;
      rem_d   = '0;
    end else if (bus.start) begin
      rem_d    = bus.load_val;
      reload_d = bus.load_val;
      p_d      = '0;
      if (bus.load_val != '0) begin
        state_d = RUN;
      end else begin
        state_d = DONE;
        done_d  = 1'b1;
      end
    end else begin
      case (state_q)
        IDLE: begin
          p_d = '0;
        end
        RUN, PAUSE: begin
          if (bus.pause) begin
            state_d = PAUSE;
          end else begin
            state_d = RUN;
            if (p_q == P_LAST) begin
              p_d    = '0;
              tick_d = 1'b1;
              if (rem_q != '0) begin
                rem_d = rem_q - SEC_ONE;
              end
              if (rem_q == SEC_ONE) begin
                done_d = 1'b1;
`ifdef TICK_TIMER_AUTO_RELOAD_EN
                rem_d  = reload_q;
`else
                state_d = DONE;
`endif
              end
            end else begin
              p_d = p_q + PRE_W'(1);
            end
          end
        end
        DONE: begin
          p_d   = '0;
          rem_d = '0;
        end
        default: begin
          state_d = IDLE;
          p_d     = '0;
          rem_d   = '0;
        end
      endcase
    end

    expired_d = (state_d == DONE);
    busy_d    = (state_d == RUN) || (state_d == PAUSE);
  end

  // Drive the bus from registers only.
  assign bus.remaining = rem_q;
  assign bus.tick_out  = tick_q;
  assign bus.done      = done_q;
  assign bus.expired   = expired_q;
  assign bus.busy      = busy_q;
  assign bus.state     = 2'(state_q);

endmodule

// File: doc/tick_timer_ctrl.md
Name: tick_timer_ctrl

Overview:
- Countdown timer controller that sequences the board's clock-divide datapath.
- Owns a gated prescaler that turns the 10 MHz system clock into one-second enable ticks.
- Runs the ticks only while the timer is active and counts a loaded seconds value down to zero.
- Drives the seconds display and alarm logic from a single clock domain; no derived clocks.

Parameters:
- DIV, 10000000, system clocks per tick; must be >= 2 and <= 2^PRE_W.
- PRE_W, 24, prescaler width.
- SEC_W, 8, width of the seconds value.

Ports:
- clk  input  1  10 MHz system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  synchronous pulse; loads load_val and begins counting.
- pause  input  1  level; while high, counting holds.
- clear  input  1  synchronous pulse; aborts and returns to IDLE.
- load_val  input  SEC_W  seconds to count; sampled only on start.
- remaining  output  SEC_W  seconds left.
- tick_out  output  1  one-cycle pulse per elapsed second.
- done  output  1  one-cycle pulse on expiry.
- expired  output  1  level; high while in DONE.
- busy  output  1  high in RUN or PAUSE.
- state  output  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.

Behaviour:
- Reset (async, any time, including mid-count):
  - state=IDLE.
  - prescaler p=0, remaining=0, reload latch=0.
  - tick_out=0, done=0, expired=0, busy=0.
- All outputs are registered. tick_out and done default to 0 every cycle unless set as described below.
- Command priority in the same cycle: clear > start > pause.
- clear, from any state:
  - state<=IDLE, p<=0, remaining<=0.
  - A tick coinciding with clear is suppressed: tick_out=0, done=0.
- start, from any state (including RUN, which restarts):
  - remaining<=load_val, reload latch<=load_val, p<=0.
  - If load_val!=0: state<=RUN.
  - If load_val==0: state<=DONE and done<=1 on the same edge.
  - pause is evaluated from the following cycle onward.
- RUN, each edge with no clear/start:
  - If pause=1: state<=PAUSE; p and remaining hold; no tick.
  - Else if p==DIV-1: p<=0, tick_out<=1, remaining<=remaining-1.
    - If remaining==1 on that edge: state<=DONE and done<=1 on the same edge.
  - Else: p<=p+1.
- Timing from start:
  - First tick edge is exactly DIV clocks after the start edge.
  - Ticks repeat every DIV clocks.
  - done edge is load_val*DIV clocks after start.
- PAUSE:
  - p and remaining frozen.
  - pause=0 -> RUN on the next edge; the count resumes from the frozen p with no lost or extra cycles.
  - Total RUN cycles to expiry stay load_val*DIV.
- DONE:
  - expired=1, remaining=0, p=0.
  - Held until start or clear.
  - pause has no effect.
- IDLE: p held at 0; pause ignored.
- Arithmetic:
  - remaining never decrements below 0; a decrement only happens in RUN with remaining>=1.
  - p never exceeds DIV-1.
- busy = (state==RUN || state==PAUSE).
- expired = (state==DONE).

Optional Feature:
- Macro: TICK_TIMER_AUTO_RELOAD_EN.
- Defined:
  - On the expiry edge, done<=1 and tick_out<=1 as normal.
  - remaining<=reload latch, p<=0, state stays RUN; the timer re-arms periodically.
  - DONE is reached only via start with load_val==0.
  - expired is 0 while reloading.
- Not defined: expiry enters DONE as specified above.

Test Plan (DIV=4, SEC_W=8):
- Reset mid-run: start with load_val=5, assert reset after 7 clocks -> immediately state=0, remaining=0, all pulses 0; state stays IDLE after release.
- Basic count: start with load_val=3 -> tick_out pulses at clocks 4, 8, 12 after start; remaining goes 2, 1, 0; done=1 and state=DONE at clock 12; expired stays high.
- Pause: start with load_val=2, pause high for clocks 2-6 -> done at clock 8+5=13; remaining unchanged during pause.
- Zero load and restart: start with load_val=0 -> done on the start edge, state=DONE. Then start with load_val=1 while in RUN at p=3 -> no tick that cycle, p=0, expiry 4 clocks later.
- Priority: clear and start in the same cycle as a tick -> IDLE, remaining=0, tick_out=0, done=0.
- With TICK_TIMER_AUTO_RELOAD_EN, load_val=2 -> done pulses at clocks 8, 16, 24; state=RUN throughout; expired=0.
